stq_svc_sched: RTL and testbench

Service scheduler for the per-unit store-queue buffers. It owns the shared service index (`svc_idx`) and its readiness threshold. It waits until every unit has stored all results for the current index, then drains matching head entries from the units one per cycle in round-robin order into a single registered output stream. It sits between the `NUM_UNITs` store-queue buffer units and the result writeback path.

---
 rtl/stq_svc_sched.sv | 167 ++++++++++++++++
 tb/tb_stq_svc_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stq_svc_sched.sv
// Store-queue service scheduler: gates on per-unit readiness for the current
// service index, then drains matching unit heads round-robin into one registered stream.
module stq_svc_sched #(
  parameter int unsigned NUM_UNITs      = 4,
  parameter int unsigned UNIT_INIT_BIT  = 4,
  parameter int unsigned DATA_PRECISION = 8,
  parameter int unsigned BITS_UNIT      = (NUM_UNITs > 1) ? $clog2(NUM_UNITs) : 1
) (
  input  logic                                clk,
  input  logic                                rst_b,
  input  logic                                global_en,
  input  logic                                start,
  input  logic [UNIT_INIT_BIT-1:0]            last_svc_idx,
  input  logic                                stream_end,
  input  logic [NUM_UNITs-1:0]                unit_svc_ready,
  input  logic [NUM_UNITs-1:0]                unit_deliver,
  input  logic [NUM_UNITs*DATA_PRECISION-1:0] unit_do,
  input  logic                                out_ready,
  output logic [NUM_UNITs-1:0]                rd_en,
  output logic [UNIT_INIT_BIT-1:0]            svc_idx,
  output logic [UNIT_INIT_BIT-1:0]            svc_threshold_idx,
  output logic                                out_valid,
  output logic [DATA_PRECISION-1:0]           out_value,
  output logic [BITS_UNIT-1:0]                out_unit,
  output logic [UNIT_INIT_BIT-1:0]            out_svc_idx,
  output logic                                busy,
  output logic                                done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_DRAIN    = 3'd2,
    S_ADVANCE  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [UNIT_INIT_BIT-1:0]    r_svc_idx;
  logic [UNIT_INIT_BIT-1:0]    w_svc_nxt;
  logic [UNIT_INIT_BIT-1:0]    r_last_idx;
  logic [UNIT_INIT_BIT-1:0]    w_last_nxt;
  logic [BITS_UNIT-1:0]        r_rr;
  logic [BITS_UNIT-1:0]        w_rr_nxt;
  logic                        r_out_valid;
  logic [DATA_PRECISION-1:0]   r_out_value;
  logic [BITS_UNIT-1:0]        r_out_unit;
  logic [UNIT_INIT_BIT-1:0]    r_out_svc_idx;

  logic                        w_gnt_found;
  logic [NUM_UNITs-1:0]        w_gnt_oh;
  logic [BITS_UNIT-1:0]        w_gnt_id;
  logic [DATA_PRECISION-1:0]   w_gnt_data;
  logic                        w_slot_free;
  logic                        w_load;

  // Round-robin pick: first requester at/after r_rr, else lowest requester (wrap).
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_oh    = '0;
    w_gnt_id    = '0;
    w_gnt_data  = '0;
    for (int j = 0; j < int'(NUM_UNITs); j++) begin
      if (!w_gnt_found && unit_deliver[j] && (BITS_UNIT'(j) >= r_rr)) begin
        w_gnt_found = 1'b1;
        w_gnt_oh[j] = 1'b1;
        w_gnt_id    = BITS_UNIT'(j);
        w_gnt_data  = unit_do[j*DATA_PRECISION +: DATA_PRECISION];
      end
    end
    for (int j = 0; j < int'(NUM_UNITs); j++) begin
      if (!w_gnt_found && unit_deliver[j]) begin
        w_gnt_found = 1'b1;
        w_gnt_oh[j] = 1'b1;
        w_gnt_id    = BITS_UNIT'(j);
        w_gnt_data  = unit_do[j*DATA_PRECISION +: DATA_PRECISION];
      end
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_svc_nxt   = r_svc_idx;
    w_last_nxt  = r_last_idx;
    w_rr_nxt    = r_rr;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_svc_nxt   = '0;
          w_last_nxt  = last_svc_idx;
          w_rr_nxt    = '0;
          w_state_nxt = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if ((&unit_svc_ready) || stream_end) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // A held output does not block leaving once no unit has this index.
        if (!w_gnt_found) begin
          w_state_nxt = S_ADVANCE;
        end else if (w_slot_free) begin
          w_load   = 1'b1;
          w_rr_nxt = (w_gnt_id == BITS_UNIT'(NUM_UNITs - 1)) ? '0
                                                             : w_gnt_id + BITS_UNIT'(1);
        end
      end
      S_ADVANCE: begin
        if (r_svc_idx == r_last_idx) begin
          w_state_nxt = S_DONE;
        end else begin
          w_svc_nxt   = r_svc_idx + UNIT_INIT_BIT'(1);
          w_state_nxt = S_WAIT_RDY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_IDLE;
      r_svc_idx  <= '0;
      r_last_idx <= '0;
      r_rr       <= '0;
    end else if (global_en) begin
      r_state    <= w_state_nxt;
      r_svc_idx  <= w_svc_nxt;
      r_last_idx <= w_last_nxt;
      r_rr       <= w_rr_nxt;
    end
  end

  // Output stage keeps draining in every state; a reload wins over a clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_out_valid   <= 1'b0;
      r_out_value   <= '0;
      r_out_unit    <= '0;
      r_out_svc_idx <= '0;
    end else if (global_en) begin
      if (w_load) begin
        r_out_valid   <= 1'b1;
        r_out_value   <= w_gnt_data;
        r_out_unit    <= w_gnt_id;
        r_out_svc_idx <= r_svc_idx;
      end else if (out_ready) begin
        r_out_valid   <= 1'b0;
      end
    end
  end

  assign rd_en             = (w_load && global_en) ? w_gnt_oh : '0;
  assign svc_idx           = r_svc_idx;
  assign svc_threshold_idx = (&r_svc_idx) ? r_svc_idx : r_svc_idx + UNIT_INIT_BIT'(1);
  assign out_valid         = r_out_valid;
  assign out_value         = r_out_value;
  assign out_unit          = r_out_unit;
  assign out_svc_idx       = r_out_svc_idx;
  assign busy              = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done              = (r_state == S_DONE);

endmodule

// File: tb/tb_stq_svc_sched.sv
// Directed bench for stq_svc_sched: FIFO unit models feed the scheduler, a
// scoreboard queue holds expected outputs in grant order.
module tb_stq_svc_sched;

  localparam int unsigned NU = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned DP = 8;
  localparam int unsigned BU = 2;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              global_en;
  logic              start;
  logic [IW-1:0]     last_svc_idx;
  logic              stream_end;
  logic [NU-1:0]     unit_svc_ready;
  logic [NU-1:0]     unit_deliver;
  logic [NU*DP-1:0]  unit_do;
  logic              out_ready;
  logic [NU-1:0]     rd_en;
  logic [IW-1:0]     svc_idx;
  logic [IW-1:0]     svc_threshold_idx;
  logic              out_valid;
  logic [DP-1:0]     out_value;
  logic [BU-1:0]     out_unit;
  logic [IW-1:0]     out_svc_idx;
  logic              busy;
  logic              done;

  stq_svc_sched #(
    .NUM_UNITs(NU), .UNIT_INIT_BIT(IW), .DATA_PRECISION(DP)
  ) dut (
    .clk(clk), .rst_b(rst_b), .global_en(global_en), .start(start),
    .last_svc_idx(last_svc_idx), .stream_end(stream_end),
    .unit_svc_ready(unit_svc_ready), .unit_deliver(unit_deliver),
    .unit_do(unit_do), .out_ready(out_ready), .rd_en(rd_en),
    .svc_idx(svc_idx), .svc_threshold_idx(svc_threshold_idx),
    .out_valid(out_valid), .out_value(out_value), .out_unit(out_unit),
    .out_svc_idx(out_svc_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DP-1:0] v;
    logic [BU-1:0] u;
    logic [IW-1:0] i;
  } exp_t;

  exp_t          exp_q[$];
  logic [NU-1:0] rd_log[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_pop = 0;
  logic [NU-1:0] s_rd_en;
  logic [DP-1:0] s_out_value;
  logic          s_out_valid;

  // Unit FIFO models: first-word-fall-through, popped by rd_en, flushed by reset.
  logic [IW-1:0] q_idx [NU][16];
  logic [DP-1:0] q_val [NU][16];
  logic [3:0]    wr_p  [NU];
  logic [3:0]    rd_p  [NU];

  always_comb begin
    unit_deliver = '0;
    unit_do      = '0;
    for (int k = 0; k < int'(NU); k++) begin
      if (wr_p[k] != rd_p[k]) begin
        unit_do[k*DP +: DP] = q_val[k][rd_p[k]];
        unit_deliver[k]     = (q_idx[k][rd_p[k]] == svc_idx);
      end
    end
  end

  always @(posedge clk or negedge rst_b) begin
    for (int k = 0; k < int'(NU); k++) begin
      if (!rst_b)        rd_p[k] <= wr_p[k];
      else if (rd_en[k]) rd_p[k] <= rd_p[k] + 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int u, input logic [IW-1:0] idx, input logic [DP-1:0] v);
    q_idx[u][wr_p[u]] = idx;
    q_val[u][wr_p[u]] = v;
    wr_p[u] = wr_p[u] + 4'd1;
  endtask

  task automatic expect_out(input logic [DP-1:0] v, input logic [BU-1:0] u, input logic [IW-1:0] i);
    exp_t e;
    e.v = v; e.u = u; e.i = i;
    exp_q.push_back(e);
  endtask

  // Per-cycle observation at the falling edge: protocol checks and scoreboard pops.
  task automatic sample();
    exp_t e;
    logic [IW-1:0] thr;
    s_rd_en     = rd_en;
    s_out_value = out_value;
    s_out_valid = out_valid;
    if (rd_en != '0) rd_log.push_back(rd_en);
    chk("rd_en_onehot0", 32'($onehot0(rd_en)), 32'd1);
    thr = (svc_idx == 4'hF) ? 4'hF : svc_idx + 4'd1;
    chk("threshold", 32'(svc_threshold_idx), 32'(thr));
    if (rst_b && global_en && out_valid && out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_out", 32'({out_value, out_unit, out_svc_idx}), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_out", 32'({out_value, out_unit, out_svc_idx}), 32'(e));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [IW-1:0] last);
    last_svc_idx = last;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (!done && cyc < maxc) begin
      step();
      cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_svc_idx"},   32'(svc_idx), 32'd0);
    chk({p, "_threshold"}, 32'(svc_threshold_idx), 32'd1);
    chk({p, "_rd_en"},     32'(rd_en), 32'd0);
    chk({p, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({p, "_out_value"}, 32'(out_value), 32'd0);
    chk({p, "_out_unit"},  32'(out_unit), 32'd0);
    chk({p, "_out_svc"},   32'(out_svc_idx), 32'd0);
    chk({p, "_busy"},      32'(busy), 32'd0);
    chk({p, "_done"},      32'(done), 32'd0);
  endtask

  initial begin
    int c;
    int pops0;
    logic [NU-1:0] basic_rd [4];

    for (int k = 0; k < int'(NU); k++) wr_p[k] = 4'd0;
    global_en      = 1'b1;
    start          = 1'b0;
    last_svc_idx   = '0;
    stream_end     = 1'b0;
    unit_svc_ready = 4'hF;
    out_ready      = 1'b1;
    rst_b          = 1'b1;
    #2 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rst_b = 1'b1;
    step();

    // Basic drain: two units, two entries each, index 0 only.
    push(0, 4'd0, 8'hA0); push(0, 4'd0, 8'hA1);
    push(2, 4'd0, 8'hC0); push(2, 4'd0, 8'hC1);
    expect_out(8'hA0, 2'd0, 4'd0); expect_out(8'hC0, 2'd2, 4'd0);
    expect_out(8'hA1, 2'd0, 4'd0); expect_out(8'hC1, 2'd2, 4'd0);
    basic_rd[0] = 4'b0001; basic_rd[1] = 4'b0100;
    basic_rd[2] = 4'b0001; basic_rd[3] = 4'b0100;
    rd_log.delete();
    run_start(4'd0);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_done(40, c);
    chk("basic_rd_count", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("basic_rd_seq", 32'(rd_log[i]), 32'(basic_rd[i]));
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("basic_busy_end", 32'(busy), 32'd0);

    // Readiness gating: unit 3 not ready holds off all pops.
    unit_svc_ready = 4'b0111;
    push(1, 4'd0, 8'hB0);
    expect_out(8'hB0, 2'd1, 4'd0);
    rd_log.delete();
    run_start(4'd0);
    repeat (5) step();
    chk("gate_quiet", 32'(rd_log.size()), 32'd0);
    unit_svc_ready = 4'hF;
    step();
    chk("gate_edge_cycle", 32'(s_rd_en), 32'd0);
    step();
    chk("gate_first_pop", 32'(s_rd_en), 32'b0010);
    wait_done(40, c);
    chk("gate_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: stall three cycles right after the first grant.
    push(0, 4'd0, 8'h30); push(0, 4'd0, 8'h31); push(0, 4'd0, 8'h32);
    push(3, 4'd0, 8'h33); push(3, 4'd0, 8'h34);
    expect_out(8'h30, 2'd0, 4'd0); expect_out(8'h33, 2'd3, 4'd0);
    expect_out(8'h31, 2'd0, 4'd0); expect_out(8'h34, 2'd3, 4'd0);
    expect_out(8'h32, 2'd0, 4'd0);
    pops0 = n_pop;
    run_start(4'd0);
    step();
    step();
    chk("bp_first_grant", 32'(s_rd_en), 32'b0001);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_rd_en_low", 32'(s_rd_en), 32'd0);
      chk("bp_value_hold", 32'(s_out_value), 32'h30);
      chk("bp_valid_hold", 32'(s_out_valid), 32'd1);
    end
    out_ready = 1'b1;
    wait_done(40, c);
    chk("bp_pop_count", 32'(n_pop - pops0), 32'd5);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Multi-index: rr pointer carries across indices within one run.
    push(0, 4'd0, 8'h40); push(0, 4'd1, 8'h41);
    push(1, 4'd1, 8'h42); push(1, 4'd2, 8'h43);
    push(2, 4'd0, 8'h44);
    push(3, 4'd2, 8'h45);
    expect_out(8'h40, 2'd0, 4'd0); expect_out(8'h44, 2'd2, 4'd0);
    expect_out(8'h41, 2'd0, 4'd1); expect_out(8'h42, 2'd1, 4'd1);
    expect_out(8'h45, 2'd3, 4'd2); expect_out(8'h43, 2'd1, 4'd2);
    run_start(4'd2);
    wait_done(80, c);
    chk("multi_svc_final", 32'(svc_idx), 32'd2);
    chk("multi_thr_final", 32'(svc_threshold_idx), 32'd3);
    chk("multi_sb_empty", 32'(exp_q.size()), 32'd0);

    // stream_end releases units that never become ready.
    unit_svc_ready = 4'b0011;
    push(2, 4'd0, 8'h50); push(3, 4'd0, 8'h51);
    expect_out(8'h50, 2'd2, 4'd0); expect_out(8'h51, 2'd3, 4'd0);
    rd_log.delete();
    run_start(4'd0);
    repeat (3) step();
    chk("se_quiet", 32'(rd_log.size()), 32'd0);
    stream_end = 1'b1;
    step();
    step();
    chk("se_release", 32'(s_rd_en), 32'b0100);
    wait_done(40, c);
    chk("se_sb_empty", 32'(exp_q.size()), 32'd0);
    unit_svc_ready = 4'hF;

    // Empty sweep to the top index: 3 cycles per index, saturating threshold,
    // and a mid-run start that must be ignored.
    run_start(4'hF);
    for (int i = 0; i < 10; i++) begin
      start        = (i == 4);
      last_svc_idx = (i == 4) ? 4'd0 : 4'hF;
      step();
    end
    start = 1'b0;
    wait_done(100, c);
    chk("sweep_cycles", 32'(10 + c), 32'd48);
    chk("sweep_svc_top", 32'(svc_idx), 32'hF);
    chk("sweep_thr_sat", 32'(svc_threshold_idx), 32'hF);
    stream_end = 1'b0;

    // Asynchronous reset while an output is pending mid-drain.
    push(1, 4'd0, 8'h60); push(1, 4'd0, 8'h61); push(1, 4'd0, 8'h62);
    run_start(4'd0);
    step();
    step();
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    rst_b = 1'b0;
    #1;
    chk_reset("rst_mid");
    step();
    step();
    rst_b = 1'b1;
    step();
    chk("rst_after_busy", 32'(busy), 32'd0);
    chk("rst_after_valid", 32'(out_valid), 32'd0);
    chk("rst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
